// File: rtl/instruction_fetch_buffer.sv
// Prefetching instruction-fetch stage for the SAYEH CPU.
// Reads 16-bit words starting at fetch_addr over the read_mem/mem_data_ready
// handshake and queues {word, address} pairs in a DEPTH-entry FIFO. The head
// entry is presented on ir_out/ir_addr with ir_valid; ir_ack pops it. flush
// drops all queued and in-flight data and restarts fetching at pc_in.
// Optional build macro FETCH_TIMEOUT_EN adds the TIMEOUT_CYCLES parameter,
// a wait counter that abandons a stalled read, and the sticky fetch_err flag.

module instruction_fetch_buffer #(
    parameter int DEPTH = 2
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc_in,
    input  logic        flush,
    output logic [15:0] addr_bus,
    output logic        read_mem,
    input  logic        mem_data_ready,
    input  logic [15:0] data_bus,
    output logic [15:0] ir_out,
    output logic [15:0] ir_addr,
    output logic        ir_valid,
    input  logic        ir_ack
`ifdef FETCH_TIMEOUT_EN
    ,
    output logic        fetch_err
`endif
);

    // DEPTH is a power of two, so pointers wrap naturally at PTR_W bits.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             r_state;
    logic               r_read_mem;
    logic [15:0]        r_fetch_addr;

    logic [15:0]        r_data_mem [DEPTH];
    logic [15:0]        r_addr_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic [15:0]        r_ir_out;
    logic [15:0]        r_ir_addr;

    // ------------------------------------------------------------------
    // Combinational decisions
    // ------------------------------------------------------------------
    state_t             w_next_state;
    logic               w_push;
    logic               w_pop;
    logic               w_timeout;
    logic [CNT_W-1:0]   w_next_count;
    logic [PTR_W-1:0]   w_next_rd_ptr;
    logic [15:0]        w_next_head_data;
    logic [15:0]        w_next_head_addr;

    // A completed read is accepted only in FETCH and never in a flush cycle.
    assign w_push = (r_state == FETCH) && mem_data_ready && !flush;
    // ir_ack is ignored on an empty FIFO and in a flush cycle.
    assign w_pop  = ir_ack && (r_count != '0) && !flush;

`ifdef FETCH_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_fetch_err;

    // Expires on the waiting cycle that would bring the count to TIMEOUT_CYCLES.
    assign w_timeout = (r_state == FETCH) && !mem_data_ready && (r_wait_cnt == WAIT_LAST);

    // Wait counter restarts for every request; fetch_err is sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt  <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                r_wait_cnt <= '0;
            end else if (!mem_data_ready) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_timeout && !flush) begin
                r_fetch_err <= 1'b1;
            end
        end
    end

    assign fetch_err = r_fetch_err;
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state logic: flush forces IDLE, otherwise request when there is room.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_next_state = r_state;
        if (flush) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_count < FULL_COUNT) begin
                        w_next_state = FETCH;
                    end
                end
                FETCH: begin
                    if (mem_data_ready || w_timeout) begin
                        w_next_state = IDLE;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    // Occupancy after this edge.
    always_comb begin
        w_next_count = r_count;
        if (flush) begin
            w_next_count = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_next_count = r_count + 1'b1;
                2'b01:   w_next_count = r_count - 1'b1;
                default: w_next_count = r_count;
            endcase
        end
    end

    // Head entry after this edge; a push into the slot that becomes the head
    // is forwarded directly since the storage write lands at the same edge.
    always_comb begin
        w_next_rd_ptr    = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
        w_next_head_data = r_data_mem[w_next_rd_ptr];
        w_next_head_addr = r_addr_mem[w_next_rd_ptr];
        if (w_push && (w_next_rd_ptr == r_wr_ptr)) begin
            w_next_head_data = data_bus;
            w_next_head_addr = r_fetch_addr;
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // FSM state register; read_mem is registered and high exactly in FETCH.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state    <= IDLE;
            r_read_mem <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_read_mem <= (w_next_state == FETCH);
        end
    end

    // Fetch address: redirected by flush, advanced (mod 2^16) on each accepted word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_addr <= 16'h0000;
        end else if (flush) begin
            r_fetch_addr <= pc_in;
        end else if (w_push) begin
            r_fetch_addr <= r_fetch_addr + 16'h0001;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_next_rd_ptr;
            r_count  <= w_next_count;
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; r_count alone decides which entries are valid.
        if (w_push) begin
            r_data_mem[r_wr_ptr] <= data_bus;
            r_addr_mem[r_wr_ptr] <= r_fetch_addr;
        end
    end

    // Head output registers: follow the head while non-empty, hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir_out  <= 16'h0000;
            r_ir_addr <= 16'h0000;
        end else if (!flush && (w_next_count != '0)) begin
            r_ir_out  <= w_next_head_data;
            r_ir_addr <= w_next_head_addr;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign addr_bus = r_fetch_addr;
    assign read_mem = r_read_mem;
    assign ir_out   = r_ir_out;
    assign ir_addr  = r_ir_addr;
    assign ir_valid = (r_count != '0);

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Self-checking bench for instruction_fetch_buffer: a cycle table for reset
// release, a scoreboard of expected {addr, word} pairs fed by a simple memory
// model, and hand-written flush / wrap / reset / timeout sequences.

module tb_instruction_fetch_buffer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc_in;
    logic        flush;
    logic [15:0] addr_bus;
    logic        read_mem;
    logic        mem_data_ready;
    logic [15:0] data_bus;
    logic [15:0] ir_out;
    logic [15:0] ir_addr;
    logic        ir_valid;
    logic        ir_ack;
`ifdef FETCH_TIMEOUT_EN
    logic        fetch_err;
`endif

    always #5 clk = ~clk;

    instruction_fetch_buffer #(
        .DEPTH(DEPTH)
`ifdef FETCH_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(4)
`endif
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_in         (pc_in),
        .flush         (flush),
        .addr_bus      (addr_bus),
        .read_mem      (read_mem),
        .mem_data_ready(mem_data_ready),
        .data_bus      (data_bus),
        .ir_out        (ir_out),
        .ir_addr       (ir_addr),
        .ir_valid      (ir_valid),
        .ir_ack        (ir_ack)
`ifdef FETCH_TIMEOUT_EN
        ,
        .fetch_err     (fetch_err)
`endif
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } word_t;

    typedef struct {
        logic        ack;
        logic        exp_read_mem;
        logic [15:0] exp_addr_bus;
        logic        exp_ir_valid;
        logic [15:0] exp_ir_out;
        logic [15:0] exp_ir_addr;
    } vec_t;

    word_t       sb_q[$];
    logic [15:0] exp_fetch_addr;
    int          mem_lat;
    bit          mem_enable;
    int          mem_wait;
    int          n_checks;
    int          n_fail;
    int          n_pops;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: memory answers, the model books what the edge must do,
    // then the outputs are sampled at the following negedge.
    task automatic tick();
        if (read_mem === 1'b1 && mem_enable && mem_wait >= mem_lat) begin
            mem_data_ready = 1'b1;
            data_bus       = addr_bus ^ 16'hA5A5;
        end else begin
            mem_data_ready = 1'b0;
            data_bus       = 16'($urandom);
        end

        if (reset) begin
            sb_q.delete();
            exp_fetch_addr = 16'h0000;
        end else if (flush) begin
            sb_q.delete();
            exp_fetch_addr = pc_in;
        end else begin
            if (ir_ack && sb_q.size() > 0) begin
                word_t w;
                w = sb_q.pop_front();
                n_pops++;
                check("pop_ir_addr", 32'(ir_addr), 32'(w.addr));
                check("pop_ir_out", 32'(ir_out), 32'(w.data));
            end
            if (mem_data_ready) begin
                check("fetch_addr_bus", 32'(addr_bus), 32'(exp_fetch_addr));
                sb_q.push_back({exp_fetch_addr, exp_fetch_addr ^ 16'hA5A5});
                exp_fetch_addr = exp_fetch_addr + 16'h0001;
            end
        end

        if (read_mem === 1'b1 && !mem_data_ready) mem_wait++;
        else mem_wait = 0;

        @(posedge clk);
        @(negedge clk);

        if (!reset) begin
            check("ir_valid_vs_model", 32'(ir_valid), 32'(sb_q.size() != 0));
            if (read_mem === 1'b1)
                check("request_only_with_room", 32'(sb_q.size() < DEPTH), 32'd1);
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        flush  = 1'b0;
        ir_ack = 1'b0;
        pc_in  = 16'h0000;
        tick();
        tick();
    endtask

    task automatic wait_q_size(input int n, input string name);
        int budget;
        budget = 40;
        while (sb_q.size() != n && budget > 0) begin
            tick();
            budget--;
        end
        check({name, "_wait_budget"}, 32'(budget > 0), 32'd1);
    endtask

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        n_pops         = 0;
        mem_lat        = 1;
        mem_enable     = 1'b1;
        mem_wait       = 0;
        exp_fetch_addr = 16'h0000;
        mem_data_ready = 1'b0;
        data_bus       = 16'h0000;
        reset          = 1'b1;
        flush          = 1'b0;
        ir_ack         = 1'b0;
        pc_in          = 16'h0000;

        //               ack   rd    addr_bus  valid ir_out    ir_addr
        vecs[0] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        vecs[1] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        vecs[2] = '{1'b0, 1'b0, 16'h0001, 1'b1, 16'hA5A5, 16'h0000};
        vecs[3] = '{1'b0, 1'b1, 16'h0001, 1'b1, 16'hA5A5, 16'h0000};
        vecs[4] = '{1'b0, 1'b1, 16'h0001, 1'b1, 16'hA5A5, 16'h0000};
        vecs[5] = '{1'b0, 1'b0, 16'h0002, 1'b1, 16'hA5A5, 16'h0000};
        vecs[6] = '{1'b0, 1'b0, 16'h0002, 1'b1, 16'hA5A5, 16'h0000};
        vecs[7] = '{1'b0, 1'b0, 16'h0002, 1'b1, 16'hA5A5, 16'h0000};
        vecs[8] = '{1'b1, 1'b0, 16'h0002, 1'b1, 16'hA5A4, 16'h0001};
        vecs[9] = '{1'b0, 1'b1, 16'h0002, 1'b1, 16'hA5A4, 16'h0001};

        @(negedge clk);

        // Reset state and reset release with one-cycle memory.
        do_reset();
        check("rst_read_mem", 32'(read_mem), 32'd0);
        check("rst_ir_valid", 32'(ir_valid), 32'd0);
        check("rst_ir_out", 32'(ir_out), 32'd0);
        check("rst_ir_addr", 32'(ir_addr), 32'd0);
        check("rst_addr_bus", 32'(addr_bus), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ir_ack = vecs[i].ack;
            tick();
            check($sformatf("vec%0d_read_mem", i), 32'(read_mem), 32'(vecs[i].exp_read_mem));
            check($sformatf("vec%0d_addr_bus", i), 32'(addr_bus), 32'(vecs[i].exp_addr_bus));
            check($sformatf("vec%0d_ir_valid", i), 32'(ir_valid), 32'(vecs[i].exp_ir_valid));
            check($sformatf("vec%0d_ir_out", i), 32'(ir_out), 32'(vecs[i].exp_ir_out));
            check($sformatf("vec%0d_ir_addr", i), 32'(ir_addr), 32'(vecs[i].exp_ir_addr));
        end
        ir_ack = 1'b0;

        // Full FIFO holds off requests; then streaming with acks.
        wait_q_size(DEPTH, "fill");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_no_read", 32'(read_mem), 32'd0);
        end
        mem_lat = 0;
        n_pops  = 0;
        ir_ack  = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        check("stream_progress", 32'(n_pops >= 12), 32'd1);
        for (int i = 0; i < 60; i++) begin
            ir_ack  = 1'($urandom_range(0, 1));
            mem_lat = (i / 7) % 3;
            tick();
        end
        ir_ack = 1'b0;

        // Flush in the same cycle the word for 0x0003 returns.
        mem_lat = 1;
        do_reset();
        reset  = 1'b0;
        ir_ack = 1'b1;
        begin
            int budget;
            budget = 60;
            while (!(read_mem === 1'b1 && addr_bus == 16'h0003 && mem_wait >= mem_lat) && budget > 0) begin
                tick();
                budget--;
            end
            check("flush_setup_budget", 32'(budget > 0), 32'd1);
        end
        flush = 1'b1;
        pc_in = 16'h0040;
        tick();
        check("flush_cycle_had_ready", 32'(mem_data_ready), 32'd1);
        check("flush_ir_valid", 32'(ir_valid), 32'd0);
        check("flush_read_mem", 32'(read_mem), 32'd0);
        check("flush_addr_bus", 32'(addr_bus), 32'h0040);
        flush  = 1'b0;
        ir_ack = 1'b0;
        tick();
        check("after_flush_read_mem", 32'(read_mem), 32'd1);
        check("after_flush_addr_bus", 32'(addr_bus), 32'h0040);
        wait_q_size(1, "flush_refetch");
        check("flush_head_addr", 32'(ir_addr), 32'h0040);
        check("flush_head_data", 32'(ir_out), 32'hA5E5);

        // Flush to 0xFFFF and wrap of the fetch address.
        flush = 1'b1;
        pc_in = 16'hFFFF;
        tick();
        flush = 1'b0;
        wait_q_size(2, "wrap_fill");
        check("wrap_head_addr", 32'(ir_addr), 32'hFFFF);
        check("wrap_head_data", 32'(ir_out), 32'h5A5A);
        check("wrap_addr_bus", 32'(addr_bus), 32'h0001);
        ir_ack = 1'b1;
        tick();
        ir_ack = 1'b0;
        check("wrap_second_addr", 32'(ir_addr), 32'h0000);
        check("wrap_second_data", 32'(ir_out), 32'hA5A5);

        // Reset while a read is outstanding and one entry is queued.
        mem_lat = 3;
        do_reset();
        reset = 1'b0;
        begin
            int budget;
            budget = 40;
            while (!(sb_q.size() == 1 && read_mem === 1'b1) && budget > 0) begin
                tick();
                budget--;
            end
            check("midreset_setup_budget", 32'(budget > 0), 32'd1);
        end
        reset = 1'b1;
        tick();
        check("midreset_read_mem", 32'(read_mem), 32'd0);
        check("midreset_ir_valid", 32'(ir_valid), 32'd0);
        check("midreset_ir_out", 32'(ir_out), 32'd0);
        check("midreset_ir_addr", 32'(ir_addr), 32'd0);
        reset = 1'b0;
        tick();
        check("restart_read_mem", 32'(read_mem), 32'd1);
        check("restart_addr_bus", 32'(addr_bus), 32'h0000);

`ifdef FETCH_TIMEOUT_EN
        // Stalled memory: abandon after 4 waiting cycles, sticky error, retry.
        mem_lat    = 0;
        mem_enable = 1'b0;
        do_reset();
        reset = 1'b0;
        tick();
        check("to_first_read", 32'(read_mem), 32'd1);
        check("to_err_clear", 32'(fetch_err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_still_waiting", 32'(read_mem), 32'd1);
        end
        tick();
        check("to_abandon", 32'(read_mem), 32'd0);
        check("to_err_set", 32'(fetch_err), 32'd1);
        tick();
        check("to_retry_read", 32'(read_mem), 32'd1);
        check("to_retry_addr", 32'(addr_bus), 32'h0000);
        check("to_err_sticky", 32'(fetch_err), 32'd1);
        mem_enable = 1'b1;
        wait_q_size(1, "to_recover");
        check("to_recover_addr", 32'(ir_addr), 32'h0000);
        check("to_err_still", 32'(fetch_err), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
